// File: rtl/lfsr_rng_pkg.sv
// Shared types and default constants for the LFSR random word generator.
package lfsr_rng_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Defaults are 64 bits wide so any WIDTH up to 64 can truncate them.
    localparam logic [63:0] DEF_TAPS = 64'h0000_0000_0000_002D;
    localparam logic [63:0] DEF_SEED = 64'h0000_0000_0000_ACE1;

endpackage

// File: rtl/lfsr_rng_if.sv
// Valid/ready word stream from the generator to its consumer.
interface lfsr_rng_if #(
    parameter int WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR shift: XOR of tapped bits enters the MSB, state moves right.
// Purely combinational, no backpressure.
module lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'h002D)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);
    assign nxt = {^(cur & TAPS), cur[WIDTH-1:1]};
endmodule

// File: rtl/lfsr_rng.sv
// LFSR random word source with valid/ready output, runtime reseed and word counter.
// First word one cycle after en; one word per cycle; out_ready low holds the word, no loss.
module lfsr_rng
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(DEF_TAPS),
    parameter int               STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             en,
    lfsr_rng_if.master       stream,
    output logic             zero_seed,
    output logic [31:0]      word_cnt
);
    fsm_t             fsm_q, fsm_n;
    logic [WIDTH-1:0] lfsr_q, lfsr_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic             valid_q, valid_n;
    logic [31:0]      cnt_q, cnt_n;
    logic             zero_q, zero_n;

    logic             seed_is_zero;
    logic [WIDTH-1:0] seed_fix;
    logic [WIDTH-1:0] adv;
    logic             hs;

    assign seed_is_zero = (seed == '0);
    assign seed_fix     = seed_is_zero ? DEFAULT_SEED : seed;
    assign hs           = valid_q & stream.out_ready;

    logic [WIDTH-1:0] chain [STEPS+1];
    assign chain[0] = lfsr_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .cur (chain[g]),
            .nxt (chain[g+1])
        );
    end

    // Degenerate tap masks could reach zero; fall back so the state never locks up.
    assign adv = (chain[STEPS] == '0) ? DEFAULT_SEED : chain[STEPS];

    always_comb begin
        fsm_n   = fsm_q;
        lfsr_n  = lfsr_q;
        data_n  = data_q;
        valid_n = valid_q;
        cnt_n   = hs ? cnt_q + 32'd1 : cnt_q;
        zero_n  = zero_q;

        if (seed_load) begin
            lfsr_n  = seed_fix;
            valid_n = 1'b0;
            fsm_n   = IDLE;
            cnt_n   = '0;
            zero_n  = seed_is_zero;
        end else begin
            case (fsm_q)
                IDLE: begin
                    valid_n = 1'b0;
                    if (en) begin
                        data_n  = lfsr_q;
                        lfsr_n  = adv;
                        valid_n = 1'b1;
                        fsm_n   = RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (en) begin
                            data_n = lfsr_q;
                            lfsr_n = adv;
                        end else begin
                            valid_n = 1'b0;
                            fsm_n   = IDLE;
                        end
                    end
                end
                default: fsm_n = IDLE;
            endcase
        end
    end

    // Seed is re-sampled on every clock edge while reset is held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q   <= IDLE;
            lfsr_q  <= seed_fix;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= seed_is_zero;
        end else begin
            fsm_q   <= fsm_n;
            lfsr_q  <= lfsr_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            cnt_q   <= cnt_n;
            zero_q  <= zero_n;
        end
    end

    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;
    assign zero_seed        = zero_q;
    assign word_cnt         = cnt_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed checks of the LFSR generator: stream values, stalls, reseed, en drop and reset.
module tb_lfsr_rng;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] seed;
    logic         seed_load;
    logic         en;
    logic         zero_seed, zero_seed2;
    logic [31:0]  word_cnt, word_cnt2;

    int checks = 0;
    int errors = 0;

    lfsr_rng_if #(.WIDTH(W)) rng_if  ();
    lfsr_rng_if #(.WIDTH(W)) rng_if2 ();
    assign rng_if2.out_ready = rng_if.out_ready;

    lfsr_rng #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .seed      (seed),
        .seed_load (seed_load),
        .en        (en),
        .stream    (rng_if),
        .zero_seed (zero_seed),
        .word_cnt  (word_cnt)
    );

    lfsr_rng #(.WIDTH(W), .STEPS(2)) u_dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .seed      (seed),
        .seed_load (seed_load),
        .en        (en),
        .stream    (rng_if2),
        .zero_seed (zero_seed2),
        .word_cnt  (word_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; seed = 16'h0001; seed_load = 1'b0; en = 1'b0; rng_if.out_ready = 1'b0;
        tick(); tick();
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", rng_if.out_valid); end
        checks++; if (rng_if.out_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h expected 0000", rng_if.out_data); end
        checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", word_cnt); end
        checks++; if (zero_seed !== 1'b0) begin errors++; $display("FAIL reset_zero got %b expected 0", zero_seed); end
        rstn = 1'b1;
        tick();
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_en got %b expected 0", rng_if.out_valid); end
    endtask

    task automatic test_sequence();
        logic [15:0] exp1 [4];
        logic [15:0] exp2 [3];
        exp1[0] = 16'h0001; exp1[1] = 16'h8000; exp1[2] = 16'h4000; exp1[3] = 16'h2000;
        exp2[0] = 16'h0001; exp2[1] = 16'h4000; exp2[2] = 16'h1000;
        en = 1'b1; rng_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rng_if.out_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b expected 1", i, rng_if.out_valid); end
            checks++; if (rng_if.out_data !== exp1[i]) begin errors++; $display("FAIL seq_data[%0d] got %h expected %h", i, rng_if.out_data, exp1[i]); end
            checks++; if (word_cnt !== 32'(i)) begin errors++; $display("FAIL seq_cnt[%0d] got %0d expected %0d", i, word_cnt, i); end
            if (i < 3) begin
                checks++; if (rng_if2.out_data !== exp2[i]) begin errors++; $display("FAIL steps2_data[%0d] got %h expected %h", i, rng_if2.out_data, exp2[i]); end
            end
        end
        en = 1'b0;
        tick();
        checks++; if (word_cnt !== 32'd4) begin errors++; $display("FAIL seq_cnt_final got %0d expected 4", word_cnt); end
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL seq_idle got %b expected 0", rng_if.out_valid); end
    endtask

    task automatic test_stall();
        en = 1'b1; rng_if.out_ready = 1'b1;
        tick();
        checks++; if (rng_if.out_data !== 16'h1000) begin errors++; $display("FAIL stall_first got %h expected 1000", rng_if.out_data); end
        tick();
        checks++; if (rng_if.out_data !== 16'h0800) begin errors++; $display("FAIL stall_pre got %h expected 0800", rng_if.out_data); end
        rng_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rng_if.out_data !== 16'h0800 || rng_if.out_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d] got %h/%b expected 0800/1", i, rng_if.out_data, rng_if.out_valid); end
            checks++; if (word_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt[%0d] got %0d expected 5", i, word_cnt); end
        end
        rng_if.out_ready = 1'b1;
        tick();
        checks++; if (rng_if.out_data !== 16'h0400) begin errors++; $display("FAIL stall_resume got %h expected 0400", rng_if.out_data); end
        checks++; if (word_cnt !== 32'd6) begin errors++; $display("FAIL stall_resume_cnt got %0d expected 6", word_cnt); end
        en = 1'b0;
        tick();
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %b expected 0", rng_if.out_valid); end
    endtask

    task automatic test_seed_zero();
        en = 1'b1; rng_if.out_ready = 1'b1;
        tick();
        checks++; if (rng_if.out_data !== 16'h0200) begin errors++; $display("FAIL sz_pre got %h expected 0200", rng_if.out_data); end
        seed = 16'h0000; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL sz_valid got %b expected 0", rng_if.out_valid); end
        checks++; if (zero_seed !== 1'b1) begin errors++; $display("FAIL sz_flag got %b expected 1", zero_seed); end
        checks++; if (word_cnt !== 32'd0) begin errors++; $display("FAIL sz_cnt got %0d expected 0", word_cnt); end
        tick();
        checks++; if (rng_if.out_data !== 16'hACE1 || rng_if.out_valid !== 1'b1)
            begin errors++; $display("FAIL sz_word got %h/%b expected ace1/1", rng_if.out_data, rng_if.out_valid); end
        tick();
        checks++; if (rng_if.out_data !== 16'h5670) begin errors++; $display("FAIL sz_next got %h expected 5670", rng_if.out_data); end
        checks++; if (word_cnt !== 32'd1 || zero_seed !== 1'b1)
            begin errors++; $display("FAIL sz_cnt_flag got %0d/%b expected 1/1", word_cnt, zero_seed); end
        seed = 16'h0001; seed_load = 1'b1;
        tick();
        seed_load = 1'b0; en = 1'b0;
        checks++; if (zero_seed !== 1'b0) begin errors++; $display("FAIL sz_clear got %b expected 0", zero_seed); end
        tick();
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL sz_idle got %b expected 0", rng_if.out_valid); end
    endtask

    task automatic test_en_drop();
        en = 1'b1; rng_if.out_ready = 1'b0;
        tick();
        checks++; if (rng_if.out_data !== 16'h0001 || rng_if.out_valid !== 1'b1)
            begin errors++; $display("FAIL ed_first got %h/%b expected 0001/1", rng_if.out_data, rng_if.out_valid); end
        en = 1'b0;
        tick(); tick();
        checks++; if (rng_if.out_data !== 16'h0001 || rng_if.out_valid !== 1'b1)
            begin errors++; $display("FAIL ed_hold got %h/%b expected 0001/1", rng_if.out_data, rng_if.out_valid); end
        rng_if.out_ready = 1'b1;
        tick();
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL ed_done got %b expected 0", rng_if.out_valid); end
        checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL ed_cnt got %0d expected 1", word_cnt); end
        tick();
        checks++; if (rng_if.out_valid !== 1'b0 || word_cnt !== 32'd1)
            begin errors++; $display("FAIL ed_stay got %b/%0d expected 0/1", rng_if.out_valid, word_cnt); end
        en = 1'b1;
        tick();
        checks++; if (rng_if.out_data !== 16'h8000) begin errors++; $display("FAIL ed_resume got %h expected 8000", rng_if.out_data); end
    endtask

    task automatic test_reset_mid();
        tick();
        checks++; if (rng_if.out_valid !== 1'b1) begin errors++; $display("FAIL rm_stream got %b expected 1", rng_if.out_valid); end
        seed = 16'h0000;
        rstn = 1'b0;
        #1;
        checks++; if (rng_if.out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b expected 0", rng_if.out_valid); end
        checks++; if (rng_if.out_data !== 16'h0000) begin errors++; $display("FAIL rm_data got %h expected 0000", rng_if.out_data); end
        checks++; if (zero_seed !== 1'b1 || word_cnt !== 32'd0)
            begin errors++; $display("FAIL rm_flag_cnt got %b/%0d expected 1/0", zero_seed, word_cnt); end
        seed = 16'h1234;
        tick();
        checks++; if (zero_seed !== 1'b0) begin errors++; $display("FAIL rm_resample got %b expected 0", zero_seed); end
        rstn = 1'b1;
        tick();
        checks++; if (rng_if.out_data !== 16'h1234 || rng_if.out_valid !== 1'b1)
            begin errors++; $display("FAIL rm_first got %h/%b expected 1234/1", rng_if.out_data, rng_if.out_valid); end
        tick();
        checks++; if (rng_if.out_data !== 16'h091A) begin errors++; $display("FAIL rm_second got %h expected 091a", rng_if.out_data); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_seed_zero();
        test_en_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
